// File: rtl/pool_window_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | Module   : pool_window_sequencer_if                                      |
// | Purpose  : Feature-map read port and pooled-result write port bundled    |
// |            for the max-pooling window sequencer.                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pool_window_sequencer_if #(
  parameter int INPUT_SIZE = 4,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_W     = 32
);
  localparam int c_grid   = INPUT_SIZE / POOL_SIZE;
  localparam int c_rd_aw  = (INPUT_SIZE * INPUT_SIZE > 1) ? $clog2(INPUT_SIZE * INPUT_SIZE) : 1;
  localparam int c_out_aw = (c_grid * c_grid > 1) ? $clog2(c_grid * c_grid) : 1;

  // Feature-map RAM read port (data returns one cycle after rd_en)
  logic                rd_en;
  logic [c_rd_aw-1:0]  rd_addr;
  logic [DATA_W-1:0]   rd_data;

  // Pooled-result valid/ready write port
  logic                out_valid;
  logic                out_ready;
  logic [c_out_aw-1:0] out_addr;
  logic [DATA_W-1:0]   out_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output out_valid, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  out_valid, out_addr, out_data,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/pool_window_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : pool_window_sequencer                                         |
// | Purpose  : Time-multiplexed max-pooling controller. Walks the            |
// |            non-overlapping POOL_SIZE x POOL_SIZE windows of an           |
// |            INPUT_SIZE x INPUT_SIZE map in row-major order using a single |
// |            shared signed comparator and emits one maximum per window.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module pool_window_sequencer #(
  parameter int INPUT_SIZE = 4,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_W     = 32
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     start,
  output logic                          busy,
  output logic                          done,
  pool_window_sequencer_if.master       bus
);

  localparam int c_grid   = INPUT_SIZE / POOL_SIZE;
  localparam int c_rd_aw  = (INPUT_SIZE * INPUT_SIZE > 1) ? $clog2(INPUT_SIZE * INPUT_SIZE) : 1;
  localparam int c_out_aw = (c_grid * c_grid > 1) ? $clog2(c_grid * c_grid) : 1;
  localparam int c_cnt_w  = (c_grid > 1) ? $clog2(c_grid) : 1;
  localparam int c_k_w    = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

  localparam logic [c_cnt_w-1:0] c_grid_last = c_cnt_w'(c_grid - 1);
  localparam logic [c_k_w-1:0]   c_k_last    = c_k_w'(POOL_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LAST = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Window position (wr, wc) and in-window offset (kr, kc)
  logic [c_cnt_w-1:0]  r_wr;
  logic [c_cnt_w-1:0]  r_wc;
  logic [c_k_w-1:0]    r_kr;
  logic [c_k_w-1:0]    r_kc;

  // Read-return tracking: r_pend marks a cycle where rd_data is meaningful,
  // r_first marks that it is the first element of a window
  logic                r_pend;
  logic                r_first;
  logic [DATA_W-1:0]   r_max;

  logic                w_k_last;
  logic                w_win_last;
  int                  w_rd_idx;
  int                  w_out_idx;

  logic                w_rd_en;
  logic [c_rd_aw-1:0]  w_rd_addr;
  logic                w_out_valid;
  logic [c_out_aw-1:0] w_out_addr;
  logic [DATA_W-1:0]   w_out_data;
  logic                w_busy;
  logic                w_done;

  assign w_k_last   = (r_kr == c_k_last) && (r_kc == c_k_last);
  assign w_win_last = (r_wr == c_grid_last) && (r_wc == c_grid_last);

  // Element index row*N + col and window index wr*M + wc
  assign w_rd_idx  = (int'(r_wr) * POOL_SIZE + int'(r_kr)) * INPUT_SIZE
                   + int'(r_wc) * POOL_SIZE + int'(r_kc);
  assign w_out_idx = int'(r_wr) * c_grid + int'(r_wc);

  // State register; reset drops everything back to idle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs; outputs outside their state are held at zero
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_rd_addr    = '0;
    w_out_valid  = 1'b0;
    w_out_addr   = '0;
    w_out_data   = '0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        w_busy    = 1'b1;
        w_rd_en   = 1'b1;
        w_rd_addr = c_rd_aw'(w_rd_idx);
        if (w_k_last) begin
          w_state_next = S_LAST;
        end
      end
      S_LAST: begin
        w_busy       = 1'b1;
        w_state_next = S_OUT;
      end
      S_OUT: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_addr  = c_out_aw'(w_out_idx);
        w_out_data  = r_max;
        if (bus.out_ready) begin
          w_state_next = w_win_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Window and in-window offset counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_wc <= '0;
      r_kr <= '0;
      r_kc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wr <= '0;
            r_wc <= '0;
            r_kr <= '0;
            r_kc <= '0;
          end
        end
        S_READ: begin
          // Offsets wrap to zero after the last element, ready for the next window
          if (r_kc == c_k_last) begin
            r_kc <= '0;
            r_kr <= (r_kr == c_k_last) ? '0 : r_kr + 1'b1;
          end else begin
            r_kc <= r_kc + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready && !w_win_last) begin
            if (r_wc == c_grid_last) begin
              r_wc <= '0;
              r_wr <= r_wr + 1'b1;
            end else begin
              r_wc <= r_wc + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shared signed comparator: first element loads, later ones win only if strictly greater
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_first <= 1'b0;
      r_max   <= '0;
    end else begin
      r_pend  <= (r_state == S_READ);
      r_first <= (r_state == S_READ) && (r_kr == '0) && (r_kc == '0);
      if (r_pend && (r_first || ($signed(bus.rd_data) > $signed(r_max)))) begin
        r_max <= bus.rd_data;
      end
    end
  end

  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = w_rd_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_addr  = w_out_addr;
  assign bus.out_data  = w_out_data;
  assign busy          = w_busy;
  assign done          = w_done;

endmodule

`default_nettype wire

// File: tb/tb_pool_window_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_pool_window_sequencer                                      |
// | Purpose  : Directed, table-driven bench for pool_window_sequencer with   |
// |            three configurations: N=4/P=2, N=5/P=2 and N=2/P=1.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pool_window_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;

  pool_window_sequencer_if #(.INPUT_SIZE(4), .POOL_SIZE(2), .DATA_W(32)) ifa ();
  pool_window_sequencer_if #(.INPUT_SIZE(5), .POOL_SIZE(2), .DATA_W(32)) ifb ();
  pool_window_sequencer_if #(.INPUT_SIZE(2), .POOL_SIZE(1), .DATA_W(32)) ifc ();

  pool_window_sequencer #(.INPUT_SIZE(4), .POOL_SIZE(2), .DATA_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(ifa));
  pool_window_sequencer #(.INPUT_SIZE(5), .POOL_SIZE(2), .DATA_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb));
  pool_window_sequencer #(.INPUT_SIZE(2), .POOL_SIZE(1), .DATA_W(32)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .bus(ifc));

  assign ifa.out_ready = ready_a;
  assign ifb.out_ready = ready_b;
  assign ifc.out_ready = ready_c;

  // Synchronous single-port RAM models
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [25];
  logic [31:0] mem_c [4];

  always @(posedge clk) if (ifa.rd_en) ifa.rd_data <= mem_a[ifa.rd_addr];
  always @(posedge clk) if (ifb.rd_en) ifb.rd_data <= (ifb.rd_addr < 5'd25) ? mem_b[ifb.rd_addr] : 32'h0;
  always @(posedge clk) if (ifc.rd_en) ifc.rd_data <= mem_c[ifc.rd_addr];

  // Selected-DUT view
  int          sel = 0;
  logic        m_valid, m_rd_en, m_done, m_busy;
  int          m_addr, m_rd_addr;
  logic [31:0] m_data;

  always_comb begin
    m_valid = 1'b0; m_addr = 0; m_data = '0; m_rd_en = 1'b0; m_rd_addr = 0; m_done = 1'b0; m_busy = 1'b0;
    case (sel)
      0: begin m_valid = ifa.out_valid; m_addr = int'(ifa.out_addr); m_data = ifa.out_data;
               m_rd_en = ifa.rd_en; m_rd_addr = int'(ifa.rd_addr); m_done = done_a; m_busy = busy_a; end
      1: begin m_valid = ifb.out_valid; m_addr = int'(ifb.out_addr); m_data = ifb.out_data;
               m_rd_en = ifb.rd_en; m_rd_addr = int'(ifb.rd_addr); m_done = done_b; m_busy = busy_b; end
      default: begin m_valid = ifc.out_valid; m_addr = int'(ifc.out_addr); m_data = ifc.out_data;
               m_rd_en = ifc.rd_en; m_rd_addr = int'(ifc.rd_addr); m_done = done_c; m_busy = busy_c; end
    endcase
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_start(input logic b);
    case (sel) 0: start_a = b; 1: start_b = b; default: start_c = b; endcase
  endtask

  task automatic set_ready(input logic b);
    case (sel) 0: ready_a = b; 1: ready_b = b; default: ready_c = b; endcase
  endtask

  // pat 0: i, 1: -16+i, 2: {3,-1,7,0}, 3: even i -> i, odd -> -100
  function automatic int pat_val(input int pat, input int i);
    int v;
    v = i;
    case (pat)
      1: v = -16 + i;
      2: case (i) 0: v = 3; 1: v = -1; 2: v = 7; default: v = 0; endcase
      3: v = (i % 2 == 0) ? i : -100;
      default: v = i;
    endcase
    return v;
  endfunction

  task automatic load(input int s, input int pat);
    if (s == 0) for (int i = 0; i < 16; i++) mem_a[i] = pat_val(pat, i);
    else if (s == 1) for (int i = 0; i < 25; i++) mem_b[i] = pat_val(pat, i);
    else for (int i = 0; i < 4; i++) mem_c[i] = pat_val(pat, i);
  endtask

  typedef struct packed {
    int              sel;
    int              pat;
    int              stall;
    int              restart;   // cycle at which a second start is pulsed (0 = none)
    int              exp_done;  // cycle (after start edge) in which done is high
    logic [3:0][31:0] exp_d;
    logic [3:0][7:0]  exp_rd;   // first four read addresses
  } vec_t;

  function automatic vec_t mk(input int s, input int p, input int st, input int rs, input int dn,
                              input int d0, input int d1, input int d2, input int d3,
                              input int r0, input int r1, input int r2, input int r3);
    vec_t v;
    v.sel = s; v.pat = p; v.stall = st; v.restart = rs; v.exp_done = dn;
    v.exp_d[0] = d0; v.exp_d[1] = d1; v.exp_d[2] = d2; v.exp_d[3] = d3;
    v.exp_rd[0] = 8'(r0); v.exp_rd[1] = 8'(r1); v.exp_rd[2] = 8'(r2); v.exp_rd[3] = 8'(r3);
    return v;
  endfunction

  task automatic run(input vec_t v);
    int cyc, nout, nrd, bad_rd, stall_left, extra;
    int hold_a;
    logic [31:0] hold_d;
    logic done_seen;
    sel = v.sel;
    load(v.sel, v.pat);
    set_ready(1'b1);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    cyc = 0; nout = 0; nrd = 0; bad_rd = 0; stall_left = v.stall; done_seen = 1'b0;
    hold_a = 0; hold_d = '0;
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      set_start((v.restart != 0) && (cyc == v.restart));
      if (m_rd_en) begin
        if (nrd < 4) check($sformatf("rd_addr[%0d] sel%0d", nrd, v.sel), 32'(m_rd_addr), 32'(v.exp_rd[nrd]));
        nrd++;
        if (v.sel == 1 && ((m_rd_addr % 5) == 4 || m_rd_addr >= 20)) bad_rd++;
      end
      if (m_valid) begin
        if (stall_left > 0) begin
          if (stall_left == v.stall) begin
            hold_a = m_addr; hold_d = m_data;
          end else begin
            check("stall_stable_addr", 32'(m_addr), 32'(hold_a));
            check("stall_stable_data", m_data, hold_d);
          end
          check("stall_rd_en", 32'(m_rd_en), 32'd0);
          set_ready(1'b0);
          stall_left--;
        end else begin
          set_ready(1'b1);
          if (nout < 4) begin
            check($sformatf("out_addr[%0d] sel%0d", nout, v.sel), 32'(m_addr), 32'(nout));
            check($sformatf("out_data[%0d] sel%0d", nout, v.sel), m_data, v.exp_d[nout]);
          end
          nout++;
          stall_left = v.stall;
        end
      end
      if (m_done) done_seen = 1'b1;
    end
    check($sformatf("done_cycle sel%0d", v.sel), done_seen ? 32'(cyc) : 32'hDEAD, 32'(v.exp_done));
    check($sformatf("out_count sel%0d", v.sel), 32'(nout), 32'd4);
    if (v.sel == 1) check("trailing_row_col_unread", 32'(bad_rd), 32'd0);
    // A start while busy or in the done cycle must not launch another run
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_start(1'b0);
      set_ready(1'b1);
      if (m_done || m_busy) extra++;
    end
    check($sformatf("no_second_run sel%0d", v.sel), 32'(extra), 32'd0);
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"},      32'(busy_a),        32'd0);
    check({tag, "_done"},      32'(done_a),        32'd0);
    check({tag, "_rd_en"},     32'(ifa.rd_en),     32'd0);
    check({tag, "_rd_addr"},   32'(ifa.rd_addr),   32'd0);
    check({tag, "_out_valid"}, 32'(ifa.out_valid), 32'd0);
    check({tag, "_out_addr"},  32'(ifa.out_addr),  32'd0);
    check({tag, "_out_data"},  ifa.out_data,       32'd0);
  endtask

  vec_t tbl [6];

  initial begin
    int cnt;
    tbl[0] = mk(0, 0, 0, 25, 25,   5,   7,  13,  15, 0, 1, 4, 5);
    tbl[1] = mk(0, 1, 0,  0, 25, -11,  -9,  -3,  -1, 0, 1, 4, 5);
    tbl[2] = mk(0, 1, 3,  0, 37, -11,  -9,  -3,  -1, 0, 1, 4, 5);
    tbl[3] = mk(0, 3, 0,  0, 25,   4,   6,  12,  14, 0, 1, 4, 5);
    tbl[4] = mk(1, 0, 0,  0, 25,   6,   8,  16,  18, 0, 1, 5, 6);
    tbl[5] = mk(2, 2, 0,  5, 13,   3,  -1,   7,   0, 0, 1, 2, 3);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_a("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Reset during READ of window 1; that window's result must never appear
    sel = 0;
    load(0, 0);
    ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_rd_en", 32'(ifa.rd_en), 32'd1);
    check("pre_rst_rd_addr", 32'(ifa.rd_addr), 32'd3);
    rst = 1'b1;
    #1;
    check_idle_a("midrst");
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.out_valid || busy_a || done_a) cnt++;
    end
    check("post_rst_silent", 32'(cnt), 32'd0);

    run(tbl[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pool_window_sequencer.md
Name: pool_window_sequencer

Overview:
- Time-multiplexed max-pooling controller for one INPUT_SIZE x INPUT_SIZE feature map held in a single-port synchronous RAM.
- After a start pulse it walks the non-overlapping POOL_SIZE x POOL_SIZE windows in row-major order.
- For each window it issues POOL_SIZE^2 reads and keeps a signed running maximum, then emits one result per window on a valid/ready write port.
- One comparator is shared across all windows; this replaces a fully parallel per-window pooling array when area matters.

Parameters:
- INPUT_SIZE, 4: feature map side length N. Must be >= POOL_SIZE.
- POOL_SIZE, 2: pooling window side P. Must be >= 1; stride = P.
- DATA_W, 32: element width, signed two's complement (Q16.15 fixed point, same format as qmult #(15,32)).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a full map; ignored unless the block is IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last result handshake.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  $clog2(N*N) (min 1)  element index = row*N + col.
- rd_data  in  DATA_W  RAM data, valid the cycle after rd_en.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; handshake = out_valid & out_ready.
- out_addr  out  $clog2((N/P)^2) (min 1)  window index = wr*(N/P) + wc.
- out_data  out  DATA_W  window maximum (signed).

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_addr=0, out_data=0. The FSM, counters and max register clear.
- Grid: M = N/P (floor) windows per side; W = M*M total. Trailing rows/cols (N mod P) are never read.
- FSM states:
  - IDLE: start=1 -> READ; window counters wr=wc=0; k=0.
  - READ: rd_en=1, one address per cycle. k runs 0..P*P-1, kr=k/P, kc=k%P. rd_addr = (wr*P+kr)*N + (wc*P+kc). After k=P*P-1 -> LAST.
  - LAST: rd_en=0; captures the final returned element; -> OUT.
  - OUT: out_valid=1, out_data=max, out_addr=wr*M+wc. All three are held stable until handshake.
    - On handshake, if not the last window: advance wc (wrap to 0 and increment wr at M-1), k=0 -> READ.
    - On handshake of the last window -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Running max:
  - The first element of a window (returned the cycle after k=0) loads unconditionally.
  - Each later element replaces max only if rd_data > max (signed compare). Ties keep the current value.
  - No arithmetic beyond the compare; width stays DATA_W.
- Timing with out_ready tied high:
  - Per window: P*P + 2 cycles.
  - From the start-sampling edge, done is high W*(P*P+2)+1 cycles later.
  - Each cycle of backpressure in OUT adds exactly one cycle; rd_en stays low while stalled.
- Boundaries:
  - start while busy, or in the DONE cycle: ignored.
  - P=1: each element is forwarded unchanged; 3 cycles per element.
  - P=N: a single window covering the whole map.
  - out_ready high outside OUT: no effect.
- rst mid-operation: immediate return to reset values. No partial result is emitted, and a new start is required.

Test Plan:
- N=4, P=2, RAM[i]=i, out_ready=1, pulse start -> outputs (addr,data) = (0,5), (1,7), (2,13), (3,15) in order. done 25 cycles after the start edge; rd_addr sequence for window 0 is 0,1,4,5.
- N=4, P=2, all elements negative with RAM[i]=-16+i (window 0 holds -16,-15,-12,-11) -> out_data[0] = -11 (0xFFFFFFF5). This confirms the signed compare; an unsigned compare would fail.
- Same map, out_ready low for 3 cycles at each OUT -> identical data and addresses. out_valid/out_addr/out_data stay stable while stalled, rd_en=0 while stalled, done at 25+12=37 cycles.
- N=5, P=2, RAM[i]=i -> W=4, outputs 6,8,16,18. Indices in row 4 and column 4 are never driven on rd_addr.
- Assert rst during READ of window 1 -> all outputs at reset values immediately and the window-1 result is never emitted. A new start with N=4, P=2, RAM[i]=i reproduces the full scenario-1 output sequence.
- start pulsed again while busy, and P=1 with N=2, RAM = {3,-1,7,0} -> the second start is ignored (exactly one done). The P=1 run emits 3,-1,7,0 at addresses 0..3 with done at 13 cycles.
